// File: rtl/spram_stream_ctrl_if.sv
// spram_stream_ctrl_if: input/output word streams plus the single-port RAM bus
interface spram_stream_ctrl_if #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic [DWIDTH-1:0] out_data;
  logic [AWIDTH-1:0] mem_address;
  logic              mem_wren;
  logic [DWIDTH-1:0] mem_data;
  logic [DWIDTH-1:0] mem_out;
  modport slave (
    input  in_valid, in_data, out_ready, mem_out,
    output in_ready, out_valid, out_data, out_last, mem_address, mem_wren, mem_data
  );
  modport master (
    output in_valid, in_data, out_ready, mem_out,
    input  in_ready, out_valid, out_data, out_last, mem_address, mem_wren, mem_data
  );
endinterface

// File: rtl/spram_stream_ctrl.sv
// spram_stream_ctrl: loads a stream into a single-port RAM and drains it back through a 2-entry FIFO
module spram_stream_ctrl #(
  parameter int AWIDTH    = 10,
  parameter int NUM_WORDS = 1024,
  parameter int DWIDTH    = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              drain_start,
  input  logic [AWIDTH:0]   cfg_len,
  output logic              busy,
  output logic              done,
  spram_stream_ctrl_if.slave s
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;
  localparam logic [AWIDTH:0] MAXLEN = (AWIDTH+1)'(NUM_WORDS);
  state_t            state;
  logic [AWIDTH:0]   len, len_c, wr_cnt, wr_next, rd_addr, out_cnt, out_next;
  logic [1:0]        cnt, cnt_pop;
  logic              inflight, rd, pop, pop_f, push_f, in_hs;
  logic [DWIDTH-1:0] fifo [2];
  // the word in flight from the RAM counts as a buffer slot and is bypassed to the output when the FIFO is empty
  always_comb begin
    len_c       = cfg_len > MAXLEN ? MAXLEN : cfg_len;
    busy        = state != IDLE;
    s.in_ready  = state == LOAD && wr_cnt < len;
    in_hs       = s.in_valid && s.in_ready;
    s.out_valid = state == DRAIN && (cnt != 2'd0 || inflight);
    s.out_data  = cnt != 2'd0 ? fifo[0] : inflight ? s.mem_out : '0;
    s.out_last  = s.out_valid && out_cnt == len - (AWIDTH+1)'(1);
    pop         = s.out_valid && s.out_ready;
    pop_f       = pop && cnt != 2'd0;
    push_f      = inflight && !(pop && cnt == 2'd0);
    cnt_pop     = cnt - {1'b0, pop_f};
    rd          = state == DRAIN && rd_addr < len &&
                  ({1'b0, cnt} + {2'b0, inflight} - {2'b0, pop}) < 3'd2;
    s.mem_wren    = in_hs;
    s.mem_address = state == LOAD ? wr_cnt[AWIDTH-1:0] : rd ? rd_addr[AWIDTH-1:0] : '0;
    s.mem_data    = state == LOAD ? s.in_data : '0;
    wr_next     = wr_cnt + (AWIDTH+1)'(in_hs);
    out_next    = out_cnt + (AWIDTH+1)'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      done     <= 1'b0;
      len      <= '0;
      wr_cnt   <= '0;
      rd_addr  <= '0;
      out_cnt  <= '0;
      cnt      <= '0;
      inflight <= 1'b0;
      fifo[0]  <= '0;
      fifo[1]  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (load_start || drain_start) begin
          state   <= load_start ? LOAD : DRAIN;
          len     <= len_c;
          wr_cnt  <= '0;
          rd_addr <= '0;
          out_cnt <= '0;
        end
        LOAD: begin
          wr_cnt <= wr_next;
          if (wr_next == len) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        DRAIN: begin
          out_cnt  <= out_next;
          rd_addr  <= rd_addr + (AWIDTH+1)'(rd);
          inflight <= rd;
          if (pop_f) fifo[0] <= fifo[1];
          if (push_f) fifo[cnt_pop[0]] <= s.mem_out;
          cnt <= cnt_pop + {1'b0, push_f};
          if (out_next == len) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spram_stream_ctrl.sv
// tb_spram_stream_ctrl: vector table for the basic LOAD/DRAIN timing, then randomized transfers
// checked against a word-array model of the RAM contents and stream order.
module tb_spram_stream_ctrl;
  localparam int AW = 10, NW = 1024, DW = 32;
  logic clk = 0, reset = 1, load_start = 0, drain_start = 0, busy, done;
  logic [AW:0] cfg_len = '0;
  int checks = 0, errors = 0;
  logic [DW-1:0] ram [NW];
  logic [DW-1:0] exp_mem [NW];

  spram_stream_ctrl_if #(.AWIDTH(AW), .DWIDTH(DW)) bus();
  spram_stream_ctrl #(.AWIDTH(AW), .NUM_WORDS(NW), .DWIDTH(DW)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .drain_start(drain_start),
    .cfg_len(cfg_len), .busy(busy), .done(done), .s(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_wren) ram[bus.mem_address] <= bus.mem_data;
    bus.mem_out <= ram[bus.mem_address];
  end
  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic ls, ds; logic [AW:0] len; logic iv; logic [DW-1:0] id; logic ordy;
    logic busy, irdy, wren; logic [AW-1:0] addr; logic ov; logic [DW-1:0] od; logic last, done;
  } vec_t;
  vec_t vt [16];

  function automatic vec_t mk(input logic ls, input logic ds, input int len, input logic iv,
                              input logic [DW-1:0] id, input logic ordy, input logic b, input logic ir,
                              input logic w, input int a, input logic ov, input logic [DW-1:0] od,
                              input logic l, input logic d);
    vec_t r;
    r.ls = ls; r.ds = ds; r.len = (AW+1)'(len); r.iv = iv; r.id = id; r.ordy = ordy;
    r.busy = b; r.irdy = ir; r.wren = w; r.addr = AW'(a); r.ov = ov; r.od = od; r.last = l; r.done = d;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input int len, input int pvalid, input bit both, input bit mid_drain);
    int L, idx;
    bit fin, exp_done, exp_rdy;
    L = len > NW ? NW : len;
    idx = 0; fin = 0;
    load_start = 1; drain_start = both; cfg_len = (AW+1)'(len); bus.in_valid = 0;
    step;
    load_start = 0; drain_start = 0;
    for (int k = 0; k < 4*L + 50 && !fin; k++) begin
      exp_done = (L == 0) ? (k == 1) : (idx == L);
      exp_rdy = idx < L;
      drain_start = mid_drain && k == 2;
      bus.in_valid = $urandom_range(99) < pvalid;
      bus.in_data = $urandom;
      @(negedge clk);
      chk("ld_ready", bus.in_ready, exp_rdy);
      chk("ld_done", done, exp_done);
      chk("ld_busy", busy, !exp_done);
      chk("ld_wren", bus.mem_wren, bus.in_valid && exp_rdy);
      if (bus.in_valid && exp_rdy) begin
        chk("ld_addr", bus.mem_address, idx);
        chk("ld_data", bus.mem_data, bus.in_data);
        exp_mem[idx] = bus.in_data;
        idx++;
      end
      fin = exp_done;
      step;
    end
    if (!fin) chk("ld_timeout", 0, 1);
    drain_start = 0; bus.in_valid = 0;
  endtask

  task automatic run_drain(input int len, input int mode, input int abort);
    int L, idx, nrd;
    bit fin, exp_done, pv, pr, pl;
    logic [DW-1:0] pd;
    L = len > NW ? NW : len;
    idx = 0; nrd = 0; fin = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    drain_start = 1; cfg_len = (AW+1)'(len); bus.out_ready = 0;
    step;
    drain_start = 0;
    for (int k = 0; k < 8*L + 50 && !fin; k++) begin
      exp_done = (L == 0) ? (k == 1) : (idx == L);
      bus.out_ready = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom_range(1));
      @(negedge clk);
      chk("dr_done", done, exp_done);
      chk("dr_busy", busy, !exp_done);
      chk("dr_wren", bus.mem_wren, 0);
      if (exp_done) chk("dr_valid_after", bus.out_valid, 0);
      if (pv && !pr) begin
        chk("dr_hold_valid", bus.out_valid, 1);
        chk("dr_hold_data", bus.out_data, pd);
        chk("dr_hold_last", bus.out_last, pl);
      end
      if (k == 0 && L > 0) nrd = 1;
      else if (bus.mem_address != 0) begin
        chk("dr_rd_addr", bus.mem_address, nrd);
        nrd++;
      end
      if (bus.out_valid && bus.out_ready) begin
        chk("dr_data", bus.out_data, exp_mem[idx]);
        chk("dr_last", bus.out_last, idx == L - 1);
        idx++;
      end
      chk("dr_occupancy", (nrd - idx) <= 2, 1);
      pv = bus.out_valid; pr = bus.out_ready; pd = bus.out_data; pl = bus.out_last;
      fin = exp_done || (abort > 0 && idx == abort);
      step;
    end
    if (!fin) chk("dr_timeout", 0, 1);
    bus.out_ready = 0;
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_out_valid"}, bus.out_valid, 0);
    chk({nm, "_in_ready"}, bus.in_ready, 0);
    chk({nm, "_wren"}, bus.mem_wren, 0);
    chk({nm, "_addr"}, bus.mem_address, 0);
    chk({nm, "_done"}, done, 0);
    chk({nm, "_out_data"}, bus.out_data, 0);
    chk({nm, "_out_last"}, bus.out_last, 0);
    step;
  endtask

  initial begin
    int L;
    bus.in_valid = 0; bus.in_data = '0; bus.out_ready = 0;
    vt[0]  = mk(0,0,0,0,'h00,0, 0,0,0,0,0,'h00,0,0);
    vt[1]  = mk(1,0,4,1,'hA0,0, 0,0,0,0,0,'h00,0,0);
    vt[2]  = mk(0,0,0,1,'hA0,0, 1,1,1,0,0,'h00,0,0);
    vt[3]  = mk(0,0,0,1,'hA1,0, 1,1,1,1,0,'h00,0,0);
    vt[4]  = mk(0,0,0,1,'hA2,0, 1,1,1,2,0,'h00,0,0);
    vt[5]  = mk(0,0,0,1,'hA3,0, 1,1,1,3,0,'h00,0,0);
    vt[6]  = mk(0,0,0,1,'hA4,0, 0,0,0,0,0,'h00,0,1);
    vt[7]  = mk(0,0,0,0,'h00,0, 0,0,0,0,0,'h00,0,0);
    vt[8]  = mk(0,1,4,0,'h00,1, 0,0,0,0,0,'h00,0,0);
    vt[9]  = mk(0,0,0,0,'h00,1, 1,0,0,0,0,'h00,0,0);
    vt[10] = mk(0,0,0,0,'h00,1, 1,0,0,1,1,'hA0,0,0);
    vt[11] = mk(0,0,0,0,'h00,1, 1,0,0,2,1,'hA1,0,0);
    vt[12] = mk(0,0,0,0,'h00,1, 1,0,0,3,1,'hA2,0,0);
    vt[13] = mk(0,0,0,0,'h00,1, 1,0,0,0,1,'hA3,1,0);
    vt[14] = mk(0,0,0,0,'h00,1, 0,0,0,0,0,'h00,0,1);
    vt[15] = mk(0,0,0,0,'h00,1, 0,0,0,0,0,'h00,0,0);

    reset = 1;
    repeat (3) step;
    idle_check("reset");
    reset = 0;

    for (int i = 0; i < 16; i++) begin
      load_start = vt[i].ls; drain_start = vt[i].ds; cfg_len = vt[i].len;
      bus.in_valid = vt[i].iv; bus.in_data = vt[i].id; bus.out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("vec%0d_in_ready", i), bus.in_ready, vt[i].irdy);
      chk($sformatf("vec%0d_wren", i), bus.mem_wren, vt[i].wren);
      chk($sformatf("vec%0d_addr", i), bus.mem_address, vt[i].addr);
      if (vt[i].wren) chk($sformatf("vec%0d_wdata", i), bus.mem_data, vt[i].id);
      chk($sformatf("vec%0d_out_valid", i), bus.out_valid, vt[i].ov);
      chk($sformatf("vec%0d_out_data", i), bus.out_data, vt[i].od);
      chk($sformatf("vec%0d_out_last", i), bus.out_last, vt[i].last);
      chk($sformatf("vec%0d_done", i), done, vt[i].done);
      step;
    end
    load_start = 0; drain_start = 0; bus.in_valid = 0; bus.out_ready = 0;
    for (int i = 0; i < 4; i++) exp_mem[i] = 32'hA0 + 32'(i);

    run_drain(4, 0, 3);
    reset = 1;
    step;
    reset = 0;
    idle_check("mid_drain_reset");
    run_drain(4, 0, 0);

    run_load(8, 70, 0, 0);
    run_drain(8, 1, 0);

    run_load(0, 100, 0, 0);
    run_drain(0, 0, 0);

    run_load(NW + 5, 100, 0, 0);
    run_drain(NW + 5, 2, 0);

    run_load(6, 60, 1, 1);
    idle_check("after_ignored_drain_a");
    idle_check("after_ignored_drain_b");

    repeat (12) begin
      L = $urandom_range(0, 40);
      run_load(L, $urandom_range(30, 100), 0, 0);
      run_drain(L, $urandom_range(0, 2), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
